// File: rtl/ir_fetch_ctrl.sv
// Instruction fetch/decode sequencer: walks PC->MAR, memory read, IR load, decode,
// operand fetch and execute, with a bounded memory wait and a retired-instruction counter.
module ir_fetch_ctrl #(
    parameter logic [7:0] HALT_OP     = 8'h07,
    parameter logic [7:0] NOP_OP      = 8'h00,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_opcode,
    input  logic        i_exec_done,
    output logic        o_pc_mar,
    output logic        o_mem_req,
    output logic        o_ir_load,
    output logic        o_pc_inc,
    output logic        o_ir_cu,
    output logic        o_ir_mbr,
    output logic        o_exec_start,
    output logic        o_busy,
    output logic        o_fault,
    output logic [2:0]  o_state,
    output logic [15:0] o_icount
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FADDR  = 3'd1,
        FMEM   = 3'd2,
        LOAD   = 3'd3,
        DECODE = 3'd4,
        OPER   = 3'd5,
        EXEC   = 3'd6,
        HALT   = 3'd7
    } state_t;

    // The wait counter holds the index of the current FMEM cycle (0-based), so the
    // last permitted wait cycle is MEM_TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] icount_q, icount_d;
    logic        fault_q, fault_d;
    logic        exec_first_q, exec_first_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            icount_q     <= '0;
            fault_q      <= 1'b0;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            icount_q     <= icount_d;
            fault_q      <= fault_d;
            exec_first_q <= exec_first_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        icount_d     = icount_q;
        fault_d      = fault_q;
        exec_first_d = 1'b0;
        o_pc_mar     = 1'b0;
        o_mem_req    = 1'b0;
        o_ir_load    = 1'b0;
        o_pc_inc     = 1'b0;
        o_ir_cu      = 1'b0;
        o_ir_mbr     = 1'b0;
        o_exec_start = 1'b0;
        o_busy       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = FADDR;
                end
            end
            FADDR: begin
                o_pc_mar = 1'b1;
                o_busy   = 1'b1;
                wait_d   = '0;
                state_d  = FMEM;
            end
            FMEM: begin
                o_mem_req = 1'b1;
                o_busy    = 1'b1;
                // Ack is checked first so a reply on the last wait cycle is not a fault.
                if (i_mem_ack) begin
                    state_d = LOAD;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            LOAD: begin
                o_ir_load = 1'b1;
                o_pc_inc  = 1'b1;
                o_busy    = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                o_ir_cu = 1'b1;
                o_busy  = 1'b1;
                if (i_opcode == HALT_OP) begin
                    icount_d = icount_q + 16'd1;
                    state_d  = HALT;
                end else if (i_opcode == NOP_OP) begin
                    icount_d = icount_q + 16'd1;
                    state_d  = FADDR;
                end else begin
                    state_d = OPER;
                end
            end
            OPER: begin
                o_ir_mbr     = 1'b1;
                o_busy       = 1'b1;
                exec_first_d = 1'b1;
                state_d      = EXEC;
            end
            EXEC: begin
                o_exec_start = exec_first_q;
                o_busy       = 1'b1;
                if (i_exec_done) begin
                    icount_d = icount_q + 16'd1;
                    state_d  = FADDR;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_fault  = fault_q;
    assign o_state  = state_q;
    assign o_icount = icount_q;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Directed bench for ir_fetch_ctrl: linear stimulus, immediate assertions on every check.
module tb_ir_fetch_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_mem_ack = 1'b0;
    logic [7:0]  i_opcode = 8'h00;
    logic        i_exec_done = 1'b0;
    logic        o_pc_mar, o_mem_req, o_ir_load, o_pc_inc, o_ir_cu, o_ir_mbr, o_exec_start;
    logic        o_busy, o_fault;
    logic [2:0]  o_state;
    logic [15:0] o_icount;

    int total = 0;
    int bad   = 0;
    int prev_exp = 0;

    ir_fetch_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_mem_ack    (i_mem_ack),
        .i_opcode     (i_opcode),
        .i_exec_done  (i_exec_done),
        .o_pc_mar     (o_pc_mar),
        .o_mem_req    (o_mem_req),
        .o_ir_load    (o_ir_load),
        .o_pc_inc     (o_pc_inc),
        .o_ir_cu      (o_ir_cu),
        .o_ir_mbr     (o_ir_mbr),
        .o_exec_start (o_exec_start),
        .o_busy       (o_busy),
        .o_fault      (o_fault),
        .o_state      (o_state),
        .o_icount     (o_icount)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock, then check state and every strobe against
    // what the expected state implies.
    task automatic step(input logic rst, input logic st, input logic ack, input logic done,
                        input int exp, input string tag);
        logic [7:0] exp_strb;
        i_rst       = rst;
        i_start     = st;
        i_mem_ack   = ack;
        i_exec_done = done;
        @(posedge i_clk);
        #1;
        exp_strb = {exp == 1, exp == 2, exp == 3, exp == 3, exp == 4, exp == 5,
                    (exp == 6) && (prev_exp == 5), (exp >= 1) && (exp <= 6)};
        chk({tag, ".state"}, 32'(o_state), 32'(exp));
        chk({tag, ".strb"},
            32'({o_pc_mar, o_mem_req, o_ir_load, o_pc_inc, o_ir_cu, o_ir_mbr, o_exec_start, o_busy}),
            32'(exp_strb));
        $display("step %s: state=%0d icount=%0d fault=%0b", tag, o_state, o_icount, o_fault);
        prev_exp = exp;
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0, 0, "rst0");
        step(1, 1, 1, 1, 0, "rst1");
        chk("rst.icount", 32'(o_icount), 32'd0);
        chk("rst.fault", 32'(o_fault), 32'd0);
        step(0, 0, 0, 0, 0, "idle");

        // Full instruction: ack on 3rd FMEM cycle, done on 3rd EXEC cycle
        i_opcode = 8'h12;
        step(0, 1, 0, 0, 1, "i1.faddr");
        step(0, 0, 0, 0, 2, "i1.fmem1");
        step(0, 0, 0, 0, 2, "i1.fmem2");
        step(0, 0, 0, 0, 2, "i1.fmem3");
        step(0, 0, 1, 0, 3, "i1.load");
        step(0, 0, 0, 0, 4, "i1.decode");
        step(0, 0, 0, 0, 5, "i1.oper");
        step(0, 0, 0, 0, 6, "i1.exec1");
        step(0, 0, 0, 0, 6, "i1.exec2");
        step(0, 0, 0, 0, 6, "i1.exec3");
        step(0, 0, 0, 1, 1, "i1.faddr2");
        chk("i1.icount", 32'(o_icount), 32'd1);

        // NOP: ack during FADDR is ignored, then ack on first FMEM cycle
        i_opcode = 8'h00;
        step(0, 0, 1, 0, 2, "nop.fmem");
        step(0, 0, 1, 0, 3, "nop.load");
        step(0, 0, 0, 0, 4, "nop.decode");
        step(0, 0, 0, 0, 1, "nop.faddr");
        chk("nop.icount", 32'(o_icount), 32'd2);

        // Ack on the 15th wait cycle wins over timeout
        step(0, 0, 0, 0, 2, "ack15.fmem1");
        for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 2, "ack15.wait");
        step(0, 0, 1, 0, 3, "ack15.load");
        chk("ack15.fault", 32'(o_fault), 32'd0);
        step(0, 0, 0, 0, 4, "ack15.decode");
        step(0, 0, 0, 0, 1, "ack15.faddr");
        chk("ack15.icount", 32'(o_icount), 32'd3);

        // No ack for 15 cycles: fault and back to IDLE
        step(0, 0, 0, 0, 2, "tmo.fmem1");
        for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 2, "tmo.wait");
        step(0, 0, 0, 0, 0, "tmo.idle");
        chk("tmo.fault", 32'(o_fault), 32'd1);
        step(0, 1, 1, 0, 1, "tmo.restart");
        step(0, 0, 1, 0, 2, "tmo.fmem");
        step(0, 0, 1, 0, 3, "tmo.load");
        chk("tmo.fault_sticky", 32'(o_fault), 32'd1);
        step(0, 0, 0, 0, 4, "tmo.decode");
        step(0, 0, 0, 0, 1, "tmo.faddr");
        chk("tmo.icount", 32'(o_icount), 32'd4);

        // Build icount=5, then reset in the middle of EXEC with exec_done high
        step(0, 0, 0, 0, 2, "pre.fmem");
        step(0, 0, 1, 0, 3, "pre.load");
        step(0, 0, 0, 0, 4, "pre.decode");
        step(0, 0, 0, 0, 1, "pre.faddr");
        i_opcode = 8'h12;
        step(0, 0, 0, 0, 2, "rx.fmem");
        step(0, 0, 1, 0, 3, "rx.load");
        step(0, 0, 0, 0, 4, "rx.decode");
        step(0, 0, 0, 0, 5, "rx.oper");
        step(0, 0, 0, 0, 6, "rx.exec1");
        step(0, 0, 0, 0, 6, "rx.exec2");
        chk("rx.icount5", 32'(o_icount), 32'd5);
        step(1, 0, 0, 1, 0, "rx.rst");
        chk("rx.icount0", 32'(o_icount), 32'd0);
        chk("rx.fault0", 32'(o_fault), 32'd0);

        // HALT opcode, then start/ack/done all ignored in HALT
        step(0, 0, 1, 0, 0, "h.idle");
        i_opcode = 8'h07;
        step(0, 1, 0, 0, 1, "h.faddr");
        step(0, 0, 0, 0, 2, "h.fmem");
        step(0, 0, 1, 0, 3, "h.load");
        step(0, 0, 0, 0, 4, "h.decode");
        step(0, 0, 0, 0, 7, "h.halt");
        chk("h.icount", 32'(o_icount), 32'd1);
        step(0, 1, 0, 0, 7, "h.start1");
        step(0, 1, 1, 1, 7, "h.start2");
        chk("h.icount_hold", 32'(o_icount), 32'd1);

        // Reset wins over start at the same edge
        step(1, 1, 0, 0, 0, "rp.rst");
        step(0, 0, 0, 0, 0, "rp.idle");
        chk("rp.icount", 32'(o_icount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
